// File: rtl/k_and_s_pkg.sv
// Shared K-and-S definitions: bus widths and the memory responder state type.
package k_and_s_pkg;

  localparam int KS_ADDR_W = 5;
  localparam int KS_DATA_W = 16;
  localparam int KS_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/ks_mem_array.sv
// Word storage: one synchronous write port, one asynchronous read port, cleared on reset.
module ks_mem_array
  import k_and_s_pkg::*;
#(
  parameter int ADDR_W = KS_ADDR_W,
  parameter int DATA_W = KS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ks_mem_responder.sv
// Memory-side responder for the K-and-S bus: fixed-latency single-word accesses plus host preload.
// state | meaning
// IDLE  | ready for a request or a host load
// WAIT  | request captured, counting down extra latency
// RESP  | access done, resp_valid high for this cycle
module ks_mem_responder
  import k_and_s_pkg::*;
#(
  parameter int ADDR_W      = KS_ADDR_W,
  parameter int DATA_W      = KS_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  input  logic              halt
);

  localparam logic [KS_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? KS_CNT_W'(WAIT_CYCLES - 1) : '0;

  mem_state_t          state_q, state_d;
  logic [KS_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                write_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                capture;
  logic                access;
  logic                acc_write;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    capture   = 1'b0;
    access    = 1'b0;
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        req_ready = !halt && !load_en;
        // Zero-latency accesses use the live request since nothing is captured yet.
        acc_write = req_write;
        acc_addr  = req_addr;
        acc_wdata = req_wdata;
        if (load_en) begin
          mem_we    = 1'b1;
          mem_waddr = load_addr;
          mem_wdata = load_data;
        end else if (req_valid && req_ready) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - KS_CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (access && acc_write) begin
      mem_we    = 1'b1;
      mem_waddr = acc_addr;
      mem_wdata = acc_wdata;
    end

    rdata_d = (access && !acc_write) ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (capture) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        write_q <= req_write;
      end
    end
  end

  ks_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (acc_addr),
    .rdata_o (mem_rdata)
  );

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign load_err   = load_en && (state_q != IDLE);

endmodule

// File: tb/tb_ks_mem_responder.sv
// Bench for ks_mem_responder: three instances (0, 1 and 3 wait cycles) against a word-level model.
module tb_ks_mem_responder;
  import k_and_s_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_write = '0;
  logic [N-1:0] req_ready;
  logic [N-1:0] resp_valid;
  logic [N-1:0] load_en = '0;
  logic [N-1:0] load_err;
  logic [N-1:0] halt = '0;
  logic [4:0]   req_addr  [N];
  logic [15:0]  req_wdata [N];
  logic [4:0]   load_addr [N];
  logic [15:0]  load_data [N];
  logic [15:0]  resp_rdata[N];

  logic [15:0] mdl_mem  [N][32];
  logic [15:0] mdl_rdata[N];

  int n_tests = 0;
  int n_fail  = 0;

  ks_mem_responder #(.ADDR_W(5), .DATA_W(16), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .load_en(load_en[0]),
    .load_addr(load_addr[0]), .load_data(load_data[0]), .load_err(load_err[0]), .halt(halt[0]));

  ks_mem_responder #(.ADDR_W(5), .DATA_W(16), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .load_en(load_en[1]),
    .load_addr(load_addr[1]), .load_data(load_data[1]), .load_err(load_err[1]), .halt(halt[1]));

  ks_mem_responder #(.ADDR_W(5), .DATA_W(16), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_ready(req_ready[2]),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .load_en(load_en[2]),
    .load_addr(load_addr[2]), .load_data(load_data[2]), .load_err(load_err[2]), .halt(halt[2]));

  function automatic int wc(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [inst %0d] t=%0t: got %h, expected %h", tag, k, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mdl_rdata[k] = '0;
      for (int a = 0; a < 32; a++) mdl_mem[k][a] = '0;
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Caller is just after a falling edge; load is written at the next rising edge.
  task automatic do_load(input int k, input logic [4:0] a, input logic [15:0] d);
    load_en[k] = 1'b1; load_addr[k] = a; load_data[k] = d;
    #1;
    chk("load_blocks_ready", k, 32'(req_ready[k]), 32'd0);
    chk("load_err_idle", k, 32'(load_err[k]), 32'd0);
    @(posedge clk);
    #1;
    load_en[k] = 1'b0;
    mdl_mem[k][a] = d;
  endtask

  // Caller is just after a falling edge. inj_n selects which busy cycle (1..W+1) gets a host load.
  task automatic do_req(input int k, input bit wr, input logic [4:0] a, input logic [15:0] d,
                        input int inj_n, input logic [4:0] la, input logic [15:0] ld);
    int w;
    int guard;
    logic [15:0] prev_rdata;
    w = wc(k);
    guard = 0;
    req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = a; req_wdata[k] = d;
    #1;
    while (!req_ready[k] && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    if (!req_ready[k]) begin
      chk("accept_timeout", k, 32'd0, 32'd1);
      req_valid[k] = 1'b0;
      return;
    end
    prev_rdata = mdl_rdata[k];
    if (wr) mdl_mem[k][a] = d;
    else    mdl_rdata[k] = mdl_mem[k][a];
    for (int n = 1; n <= w + 1; n++) begin
      @(negedge clk);
      if (n == 1) req_valid[k] = 1'b0;
      load_en[k] = (n == inj_n); load_addr[k] = la; load_data[k] = ld;
      #1;
      chk("resp_valid", k, 32'(resp_valid[k]), 32'(n == w + 1));
      chk("busy_ready", k, 32'(req_ready[k]), 32'd0);
      chk("load_err", k, 32'(load_err[k]), 32'(n == inj_n));
      if (n == w + 1) chk("resp_rdata", k, 32'(resp_rdata[k]), 32'(mdl_rdata[k]));
      else            chk("rdata_held", k, 32'(resp_rdata[k]), 32'(prev_rdata));
    end
    @(negedge clk);
    load_en[k] = 1'b0;
    #1;
    chk("ready_again", k, 32'(req_ready[k]), 32'(!halt[k]));
    chk("resp_clear", k, 32'(resp_valid[k]), 32'd0);
    chk("load_err_clear", k, 32'(load_err[k]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      req_addr[k] = '0; req_wdata[k] = '0; load_addr[k] = '0; load_data[k] = '0;
    end
    model_reset();
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_ready", k, 32'(req_ready[k]), 32'd1);
      chk("rst_resp_valid", k, 32'(resp_valid[k]), 32'd0);
      chk("rst_rdata", k, 32'(resp_rdata[k]), 32'd0);
      chk("rst_load_err", k, 32'(load_err[k]), 32'd0);
    end
    nxt(); rst_n = 1'b1;

    // Read of reset-cleared word, one wait cycle.
    nxt(); do_req(1, 1'b0, 5'd3, 16'h0, 0, 5'd0, 16'h0);

    // Preload then immediate zero-latency read.
    nxt(); do_load(0, 5'd7, 16'hBEEF);
    nxt(); do_req(0, 1'b0, 5'd7, 16'h0, 0, 5'd0, 16'h0);

    // Write top address then read it back with three wait cycles.
    nxt(); do_req(2, 1'b1, 5'd31, 16'h1234, 0, 5'd0, 16'h0);
    nxt(); do_req(2, 1'b0, 5'd31, 16'h0, 0, 5'd0, 16'h0);

    // Host loads while busy are dropped: one in WAIT, one in RESP.
    nxt(); do_req(2, 1'b0, 5'd9, 16'h0, 2, 5'd9, 16'h5555);
    nxt(); do_req(2, 1'b0, 5'd9, 16'h0, 0, 5'd0, 16'h0);
    nxt(); do_req(1, 1'b0, 5'd10, 16'h0, 2, 5'd10, 16'hA5A5);
    nxt(); do_req(1, 1'b0, 5'd10, 16'h0, 0, 5'd0, 16'h0);

    // Halt holds off a pending request; load still taken while halted.
    nxt(); halt[1] = 1'b1; do_load(1, 5'd12, 16'hC0DE);
    nxt();
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 5'd12;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("halt_ready", 1, 32'(req_ready[1]), 32'd0);
      chk("halt_no_resp", 1, 32'(resp_valid[1]), 32'd0);
      nxt();
    end
    halt[1] = 1'b0;
    #1;
    chk("halt_release_ready", 1, 32'(req_ready[1]), 32'd1);
    do_req(1, 1'b0, 5'd12, 16'h0, 0, 5'd0, 16'h0);

    // Reset during the WAIT of a write: the write must never land.
    nxt();
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 5'd5; req_wdata[2] = 16'hAAAA;
    #1;
    chk("rst_test_accept", 2, 32'(req_ready[2]), 32'd1);
    nxt(); req_valid[2] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < N; k++) begin
      chk("midrst_ready", k, 32'(req_ready[k]), 32'd1);
      chk("midrst_resp_valid", k, 32'(resp_valid[k]), 32'd0);
      chk("midrst_rdata", k, 32'(resp_rdata[k]), 32'd0);
    end
    nxt(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("postrst_no_resp", 2, 32'(resp_valid[2]), 32'd0);
      nxt();
    end
    do_req(2, 1'b0, 5'd5, 16'h0, 0, 5'd0, 16'h0);

    // Randomized mix of loads, writes and reads, with occasional dropped loads while busy.
    for (int it = 0; it < 180; it++) begin
      int k;
      int op;
      int inj;
      logic [4:0]  a;
      logic [15:0] d;
      k   = int'($urandom_range(0, N - 1));
      op  = int'($urandom_range(0, 3));
      a   = 5'($urandom);
      d   = 16'($urandom);
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, wc(k) + 1)) : 0;
      nxt();
      case (op)
        0:       do_load(k, a, d);
        1:       do_req(k, 1'b1, a, d, inj, 5'($urandom), 16'($urandom));
        default: do_req(k, 1'b0, a, 16'h0, inj, 5'($urandom), 16'($urandom));
      endcase
    end

    // Final sweep: every word of every instance matches the model.
    for (int k = 0; k < N; k++) begin
      for (int a = 0; a < 32; a++) begin
        nxt(); do_req(k, 1'b0, 5'(a), 16'h0, 0, 5'd0, 16'h0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
